// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the single 8-bit TX AXI-stream of the MAC.
// Oversized frames are truncated with tuser forced, and the rest of the source frame is drained.
module eth_tx_frame_arbiter #(
  parameter int PORTS         = 2,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int GW            = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*PORTS-1:0]   s_axis_tdata,
  input  logic [PORTS-1:0]     s_axis_tvalid,
  output logic [PORTS-1:0]     s_axis_tready,
  input  logic [PORTS-1:0]     s_axis_tlast,
  input  logic [PORTS-1:0]     s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 grant_valid,
  output logic [GW-1:0]        grant_idx,
  output logic                 oversize_pulse
);

  // state | meaning
  // IDLE  | no owner; pick next requester round-robin (one bubble cycle)
  // PASS  | granted source passed straight through to the MAC
  // DRAIN | frame truncated; swallow the source's remaining beats up to tlast
  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

  localparam logic [15:0] LAST_CNT = 16'(MAX_FRAME_LEN - 1);
  localparam logic [15:0] MAX_CNT  = 16'(MAX_FRAME_LEN);

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_idx_q, grant_idx_d;
  logic [15:0]       byte_cnt_q, byte_cnt_d;
  logic              oversize_pulse_q, oversize_pulse_d;

  logic [PORTS-1:0]  grant_oh;
  logic [7:0]        sel_tdata;
  logic              sel_tvalid;
  logic              sel_tlast;
  logic              sel_tuser;
  logic              oversize_beat;
  logic              hs;
  logic [GW-1:0]     req_idx;
  logic              req_found;
  int                scan_idx;

  always_comb begin
    grant_oh   = '0;
    sel_tdata  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tuser  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_idx_q == GW'(i)) begin
        grant_oh[i] = 1'b1;
        sel_tdata   = s_axis_tdata[8*i +: 8];
        sel_tvalid  = s_axis_tvalid[i];
        sel_tlast   = s_axis_tlast[i];
        sel_tuser   = s_axis_tuser[i];
      end
    end
  end

  // Scan upward from the port after the last grantee, wrapping around.
  always_comb begin
    req_found = 1'b0;
    req_idx   = grant_idx_q;
    scan_idx  = 0;
    for (int k = 1; k <= PORTS; k++) begin
      scan_idx = (int'(grant_idx_q) + k) % PORTS;
      for (int i = 0; i < PORTS; i++) begin
        if (!req_found && (i == scan_idx) && s_axis_tvalid[i]) begin
          req_found = 1'b1;
          req_idx   = GW'(i);
        end
      end
    end
  end

  // Last permitted beat without tlast: force end-of-frame marked bad.
  assign oversize_beat = (byte_cnt_q == LAST_CNT) && !sel_tlast;

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = '0;
    case (state_q)
      PASS: begin
        m_axis_tdata  = sel_tdata;
        m_axis_tvalid = sel_tvalid;
        m_axis_tlast  = sel_tlast | oversize_beat;
        m_axis_tuser  = sel_tuser | oversize_beat;
        s_axis_tready = grant_oh & {PORTS{m_axis_tready}};
      end
      DRAIN: s_axis_tready = grant_oh;
      default: ;
    endcase
  end

  assign hs = m_axis_tvalid & m_axis_tready;

  always_comb begin
    state_d          = state_q;
    grant_idx_d      = grant_idx_q;
    byte_cnt_d       = byte_cnt_q;
    oversize_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_found) begin
          grant_idx_d = req_idx;
          byte_cnt_d  = '0;
          state_d     = PASS;
        end
      end
      PASS: begin
        if (hs) begin
          if (byte_cnt_q < MAX_CNT) byte_cnt_d = byte_cnt_q + 16'd1;
          if (sel_tlast) begin
            state_d = IDLE;
          end else if (oversize_beat) begin
            state_d          = DRAIN;
            oversize_pulse_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (sel_tvalid && sel_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      grant_idx_q      <= GW'(PORTS - 1);
      byte_cnt_q       <= '0;
      oversize_pulse_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      grant_idx_q      <= grant_idx_d;
      byte_cnt_q       <= byte_cnt_d;
      oversize_pulse_q <= oversize_pulse_d;
    end
  end

  assign grant_valid    = (state_q != IDLE);
  assign grant_idx      = grant_idx_q;
  assign oversize_pulse = oversize_pulse_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: cycle-driven AXI-stream sources and a MAC-side recorder.
module tb_eth_tx_frame_arbiter;
  localparam int PORTS = 2;
  localparam int MAXL  = 1518;

  logic               clk = 1'b0;
  logic               rst;
  logic [8*PORTS-1:0] s_axis_tdata;
  logic [PORTS-1:0]   s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [7:0]         m_axis_tdata;
  logic               m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic               grant_valid, oversize_pulse;
  logic [0:0]         grant_idx;

  eth_tx_frame_arbiter #(.PORTS(PORTS), .MAX_FRAME_LEN(MAXL)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .oversize_pulse(oversize_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int q_len[PORTS][$];
  int q_base[PORTS][$];
  int pos[PORTS];
  int start_cyc[PORTS];

  logic [7:0] o_data[$];
  logic       o_last[$];
  logic       o_user[$];
  int         o_port[$];
  int         o_cyc[$];
  int         pulse_cnt;
  int         bad_rdy_cnt;

  task automatic clear_run();
    for (int p = 0; p < PORTS; p++) begin
      q_len[p].delete();
      q_base[p].delete();
      pos[p] = 0;
      start_cyc[p] = 0;
    end
    o_data.delete(); o_last.delete(); o_user.delete(); o_port.delete(); o_cyc.delete();
    pulse_cnt = 0;
    bad_rdy_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0; s_axis_tdata = '0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Drives queued frames cycle by cycle and records every accepted output beat.
  task automatic run(input bit rand_rdy, input int stop_beats, input int budget);
    int c;
    bit done, timed_out, all_empty;
    c = 0; done = 0; timed_out = 0;
    while (!done) begin
      for (int p = 0; p < PORTS; p++) begin
        s_axis_tuser[p] = 1'b0;
        if (q_len[p].size() > 0 && c >= start_cyc[p]) begin
          s_axis_tvalid[p]         = 1'b1;
          s_axis_tdata[8*p +: 8]   = 8'(q_base[p][0] + pos[p]);
          s_axis_tlast[p]          = (pos[p] == q_len[p][0] - 1);
        end else begin
          s_axis_tvalid[p]         = 1'b0;
          s_axis_tdata[8*p +: 8]   = 8'h00;
          s_axis_tlast[p]          = 1'b0;
        end
      end
      m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tready) begin
        o_data.push_back(m_axis_tdata);
        o_last.push_back(m_axis_tlast);
        o_user.push_back(m_axis_tuser);
        o_port.push_back(int'(grant_idx));
        o_cyc.push_back(c);
      end
      if (oversize_pulse) pulse_cnt++;
      for (int p = 0; p < PORTS; p++) begin
        if (s_axis_tready[p] && (!grant_valid || int'(grant_idx) != p)) bad_rdy_cnt++;
        if (s_axis_tvalid[p] && s_axis_tready[p]) begin
          pos[p]++;
          if (pos[p] == q_len[p][0]) begin
            void'(q_len[p].pop_front());
            void'(q_base[p].pop_front());
            pos[p] = 0;
          end
        end
      end
      c++;
      all_empty = 1;
      for (int p = 0; p < PORTS; p++) if (q_len[p].size() != 0) all_empty = 0;
      if (stop_beats > 0 && o_data.size() >= stop_beats) done = 1;
      else if (all_empty) done = 1;
      else if (c >= budget) begin done = 1; timed_out = 1; end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b1;
    n_cmp++;
    if (timed_out) begin
      n_err++;
      $display("FAIL run_timeout: ran %0d cycles without completing, required within %0d", c, budget);
    end
  endtask

  // Index of the first beat deviating from the expected frame, or -1.
  function automatic int first_bad(input int from, input int n, input int base, input int port);
    for (int i = 0; i < n; i++) begin
      if (from + i >= o_data.size()) return i;
      if (o_data[from+i] !== 8'(base + i) || o_port[from+i] != port ||
          o_last[from+i] !== (i == n - 1) || (i < n - 1 && o_user[from+i] !== 1'b0))
        return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0; s_axis_tdata = '0;
    m_axis_tready = 1'b1;
    #2;
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    n_cmp++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
    n_cmp++; if (m_axis_tuser !== 1'b0) begin n_err++; $display("FAIL reset_tuser: got %b want 0", m_axis_tuser); end
    n_cmp++; if (m_axis_tdata !== 8'h00) begin n_err++; $display("FAIL reset_tdata: got %h want 00", m_axis_tdata); end
    n_cmp++; if (s_axis_tready !== 2'b00) begin n_err++; $display("FAIL reset_sready: got %b want 00", s_axis_tready); end
    n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL reset_grant_valid: got %b want 0", grant_valid); end
    n_cmp++; if (grant_idx !== 1'b1) begin n_err++; $display("FAIL reset_grant_idx: got %b want 1", grant_idx); end
    n_cmp++; if (oversize_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse: got %b want 0", oversize_pulse); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int fb;
    clear_run();
    q_len[0].push_back(60); q_base[0].push_back(8'h10);
    run(0, 0, 500);
    n_cmp++; if (o_data.size() != 60) begin n_err++; $display("FAIL single_count: got %0d beats want 60", o_data.size()); end
    fb = first_bad(0, 60, 8'h10, 0);
    n_cmp++; if (fb != -1) begin n_err++; $display("FAIL single_data: first bad beat %0d want none", fb); end
    n_cmp++; if (o_cyc.size() == 0 || o_cyc[0] != 1) begin n_err++; $display("FAIL single_latency: first beat cycle %0d want 1", (o_cyc.size() == 0) ? -1 : o_cyc[0]); end
    n_cmp++; if (o_user.size() < 60 || o_user[59] !== 1'b0) begin n_err++; $display("FAIL single_tuser: last beat tuser wrong, want 0"); end
    n_cmp++; if (pulse_cnt != 0) begin n_err++; $display("FAIL single_pulse: got %0d pulses want 0", pulse_cnt); end
  endtask

  task automatic test_back_to_back();
    int bad_frame, bad_gap, fb;
    do_reset();
    clear_run();
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < PORTS; p++) begin
        q_len[p].push_back(64);
        q_base[p].push_back(16*k + 100*p);
      end
    run(0, 0, 2000);
    n_cmp++; if (o_data.size() != 384) begin n_err++; $display("FAIL b2b_count: got %0d beats want 384", o_data.size()); end
    bad_frame = -1;
    for (int f = 0; f < 6; f++) begin
      fb = first_bad(64*f, 64, 16*(f/2) + 100*(f%2), f % 2);
      if (fb != -1 && bad_frame < 0) bad_frame = f;
    end
    n_cmp++; if (bad_frame != -1) begin n_err++; $display("FAIL b2b_order: frame %0d wrong, want order 0,1,0,1,0,1 intact", bad_frame); end
    bad_gap = -1;
    for (int f = 1; f < 6; f++) begin
      if (o_cyc.size() < 64*f + 1) begin
        if (bad_gap < 0) bad_gap = 0;
      end else if (o_cyc[64*f] - o_cyc[64*f-1] != 2 && bad_gap < 0) begin
        bad_gap = o_cyc[64*f] - o_cyc[64*f-1];
      end
    end
    n_cmp++; if (bad_gap != -1) begin n_err++; $display("FAIL b2b_bubble: frame gap %0d cycles want 2", bad_gap); end
    n_cmp++; if (bad_rdy_cnt != 0) begin n_err++; $display("FAIL b2b_ready: %0d non-granted ready cycles want 0", bad_rdy_cnt); end
  endtask

  task automatic test_stall();
    int fb;
    clear_run();
    q_len[1].push_back(100); q_base[1].push_back(8'h33);
    run(1, 0, 2000);
    n_cmp++; if (o_data.size() != 100) begin n_err++; $display("FAIL stall_count: got %0d beats want 100", o_data.size()); end
    fb = first_bad(0, 100, 8'h33, 1);
    n_cmp++; if (fb != -1) begin n_err++; $display("FAIL stall_data: first bad beat %0d want none", fb); end
  endtask

  task automatic test_oversize();
    int fb, gap;
    clear_run();
    q_len[1].push_back(1600); q_base[1].push_back(0);
    q_len[0].push_back(20);   q_base[0].push_back(8'h55);
    start_cyc[0] = 5;
    run(0, 0, 5000);
    n_cmp++; if (o_data.size() != 1538) begin n_err++; $display("FAIL ovs_count: got %0d beats want 1538", o_data.size()); end
    fb = first_bad(0, 1518, 0, 1);
    n_cmp++; if (fb != -1) begin n_err++; $display("FAIL ovs_trunc: first bad beat %0d want none (tlast at 1517)", fb); end
    n_cmp++; if (o_user.size() < 1518 || o_user[1517] !== 1'b1) begin n_err++; $display("FAIL ovs_tuser: beat 1517 tuser not set, want 1"); end
    n_cmp++; if (pulse_cnt != 1) begin n_err++; $display("FAIL ovs_pulse: got %0d pulses want 1", pulse_cnt); end
    fb = first_bad(1518, 20, 8'h55, 0);
    n_cmp++; if (fb != -1) begin n_err++; $display("FAIL ovs_next: port0 frame first bad beat %0d want none", fb); end
    gap = (o_cyc.size() >= 1519) ? o_cyc[1518] - o_cyc[1517] : -1;
    n_cmp++; if (gap != 84) begin n_err++; $display("FAIL ovs_drain: gap %0d cycles want 84", gap); end
    n_cmp++; if (bad_rdy_cnt != 0) begin n_err++; $display("FAIL ovs_ready: %0d non-granted ready cycles want 0", bad_rdy_cnt); end
  endtask

  task automatic test_max_len();
    int fb;
    clear_run();
    q_len[0].push_back(1518); q_base[0].push_back(8'h07);
    run(0, 0, 3000);
    n_cmp++; if (o_data.size() != 1518) begin n_err++; $display("FAIL maxlen_count: got %0d beats want 1518", o_data.size()); end
    fb = first_bad(0, 1518, 8'h07, 0);
    n_cmp++; if (fb != -1) begin n_err++; $display("FAIL maxlen_data: first bad beat %0d want none", fb); end
    n_cmp++; if (o_user.size() < 1518 || o_user[1517] !== 1'b0) begin n_err++; $display("FAIL maxlen_tuser: last beat tuser set, want 0"); end
    n_cmp++; if (pulse_cnt != 0) begin n_err++; $display("FAIL maxlen_pulse: got %0d pulses want 0", pulse_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_run();
    q_len[0].push_back(60); q_base[0].push_back(8'h20);
    q_len[1].push_back(40); q_base[1].push_back(8'h90);
    run(0, 30, 500);
    n_cmp++; if (o_data.size() != 30 || o_port[0] != 0) begin n_err++; $display("FAIL rmid_pre: %0d beats want 30 from port 0", o_data.size()); end
    s_axis_tvalid = 2'b11;
    s_axis_tdata  = {8'h90, 8'h3E};
    s_axis_tlast  = 2'b00;
    rst = 1'b1;
    #1;
    n_cmp++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00) begin n_err++; $display("FAIL rmid_out: tvalid %b tdata %h want 0/00", m_axis_tvalid, m_axis_tdata); end
    n_cmp++; if (s_axis_tready !== 2'b00) begin n_err++; $display("FAIL rmid_sready: got %b want 00", s_axis_tready); end
    n_cmp++; if (grant_valid !== 1'b0 || grant_idx !== 1'b1) begin n_err++; $display("FAIL rmid_grant: valid %b idx %b want 0/1", grant_valid, grant_idx); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (grant_valid !== 1'b1 || grant_idx !== 1'b0) begin n_err++; $display("FAIL rmid_port0_first: valid %b idx %b want 1/0", grant_valid, grant_idx); end
    rst = 1'b1;
    s_axis_tvalid = 2'b10;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (grant_valid !== 1'b1 || grant_idx !== 1'b1) begin n_err++; $display("FAIL rmid_port1_only: valid %b idx %b want 1/1", grant_valid, grant_idx); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_oversize();
    test_max_len();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
